// File: rtl/scale_offset_pipe.sv
// scale_offset_pipe: two-stage scale/offset datapath with an optional running
// accumulator and valid/ready handshakes on both sides.
//   stage 1 : p = a*SCALE (reduced to OUT_WIDTH), plus mode/clr tags
//   stage 2 : out = p + OFFSET (affine) or acc_new + OFFSET (accumulate)
// Build option: define SCALE_OFFSET_SAT_EN to saturate every stage result to
// 2^OUT_WIDTH-1 instead of wrapping.
module scale_offset_pipe #(
  parameter int          WIDTH     = 4,
  parameter int          OUT_WIDTH = 6,
  parameter int unsigned SCALE     = 4,
  parameter int unsigned OFFSET    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 acc_mode,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [OUT_WIDTH-1:0] p;
    logic                 mode;
    logic                 clr;
  } s1_t;

  logic [STAGES:1]      vld_pipe;
  s1_t                  s1;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] p_in, acc_new, base, res, acc_next;
  logic                 advance;

  // One advance signal moves the whole pipe; a held output freezes everything.
  assign advance   = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

`ifdef SCALE_OFFSET_SAT_EN
  localparam int PW = WIDTH + 32;
  localparam int SW = OUT_WIDTH + 33;
  localparam logic [OUT_WIDTH-1:0] MAX = '1;

  logic [PW-1:0]      prod_full;
  logic [OUT_WIDTH:0] acc_sum;
  logic [SW-1:0]      off_full;

  // Full-width product, clamped to the result range.
  always_comb begin
    prod_full = PW'(in_data) * PW'(SCALE);
    p_in      = ((prod_full >> OUT_WIDTH) != '0) ? MAX : prod_full[OUT_WIDTH-1:0];
  end

  // Stage-2 arithmetic with clamping at each step; acc sticks at MAX until cleared.
  always_comb begin
    acc_sum  = {1'b0, acc} + {1'b0, s1.p};
    acc_new  = s1.clr ? s1.p : (acc_sum[OUT_WIDTH] ? MAX : acc_sum[OUT_WIDTH-1:0]);
    base     = s1.mode ? acc_new : s1.p;
    off_full = SW'(base) + SW'(OFFSET);
    res      = ((off_full >> OUT_WIDTH) != '0) ? MAX : off_full[OUT_WIDTH-1:0];
  end
`else
  // Product computed directly at result width, so it wraps modulo 2^OUT_WIDTH.
  always_comb p_in = OUT_WIDTH'(in_data) * OUT_WIDTH'(SCALE);

  // Stage-2 arithmetic, wrapping.
  always_comb begin
    acc_new = s1.clr ? s1.p : acc + s1.p;
    base    = s1.mode ? acc_new : s1.p;
    res     = base + OUT_WIDTH'(OFFSET);
  end
`endif

  // Next accumulator value: accumulate items own it, affine items may only clear it.
  always_comb begin
    acc_next = acc;
    if (s1.mode)     acc_next = acc_new;
    else if (s1.clr) acc_next = '0;
  end

  // Pipeline registers; acc and out_data change only when a real item enters stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      out_data <= '0;
      acc      <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid) s1 <= '{p: p_in, mode: acc_mode, clr: acc_clr};
      if (vld_pipe[1]) begin
        out_data <= res;
        acc      <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_scale_offset_pipe.sv
// Scoreboard bench for scale_offset_pipe: expected results are computed by a
// small reference model at acceptance time and compared as results emerge.
module tb_scale_offset_pipe;
  localparam int SCALE  = 4;
  localparam int OFFSET = 3;
  localparam int MAXV   = 63;

  logic       clk = 0, rst_n = 1;
  logic       in_valid, in_ready, acc_mode, acc_clr, out_valid, out_ready;
  logic [3:0] in_data;
  logic [5:0] out_data;

  logic       o_in_valid, o_in_ready, o_out_valid;
  logic       o_mode = 0, o_clr = 0, o_out_ready = 1;
  logic [7:0] o_in_data;
  logic [9:0] o_out_data;

  int   n_chk = 0, n_pass = 0, cyc = 0, m_acc = 0;
  int   q[$];
  int   pops[$];
  bit   prev_stall = 0;
  logic [5:0] prev_data;

  scale_offset_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  scale_offset_pipe #(.WIDTH(8), .OUT_WIDTH(10), .SCALE(5), .OFFSET(4)) dut_o (
    .clk(clk), .rst_n(rst_n), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .in_data(o_in_data), .acc_mode(o_mode), .acc_clr(o_clr),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .out_data(o_out_data));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int fit(input int x);
`ifdef SCALE_OFFSET_SAT_EN
    return (x > MAXV) ? MAXV : x;
`else
    return x % (MAXV + 1);
`endif
  endfunction

  function automatic int model(input int a, input bit m, input bit c);
    int p, b;
    p = fit(a * SCALE);
    if (m) begin
      m_acc = c ? p : fit(m_acc + p);
      b = m_acc;
    end else begin
      if (c) m_acc = 0;
      b = p;
    end
    return fit(b + OFFSET);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int a, input bit m, input bit c);
    int n = 0;
    in_valid = 1; in_data = 4'(a); acc_mode = m; acc_clr = c;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    q.push_back(model(a, m, c));
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin @(negedge clk); #1; n++; end
    chk("drain_q", q.size(), 0);
    @(negedge clk); #1;
    chk("drain_v", out_valid, 0);
    @(posedge clk); #1;
  endtask

  // Output monitor: scoreboard compare, stall stability and stalled in_ready.
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        pops.push_back(cyc);
        if (q.size() == 0) chk("spurious", out_valid, 0);
        else chk("data", out_data, q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    in_valid = 0; in_data = 0; acc_mode = 0; acc_clr = 0; out_ready = 1;
    o_in_valid = 0; o_in_data = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Affine a=5 -> 23, two cycles after acceptance
    send(5, 0, 0);
    @(negedge clk); chk("lat1_valid", out_valid, 0);
    @(negedge clk); chk("lat2_valid", out_valid, 1); chk("lat2_data", out_data, 23);
    @(posedge clk); #1;
    send(1, 1, 0);                      // acc still 0 -> 7
    drain();

    // Back-to-back accumulate burst: 7, 15, 27 on consecutive cycles
    pops.delete();
    send(1, 1, 1); send(2, 1, 0); send(3, 1, 0);
    drain();
    chk("burst_count", pops.size(), 3);
    if (pops.size() == 3) begin
      chk("burst_gap1", pops[1] - pops[0], 1);
      chk("burst_gap2", pops[2] - pops[1], 1);
    end

    // Overflow: 63 then 59 (wrap) or 63 (saturate)
    send(15, 1, 1); send(15, 1, 0);
    drain();

    // Affine with clr clears acc; following accumulate starts from 0
    send(3, 0, 1); send(1, 1, 0);
    drain();

    // Backpressure: out_ready low for 3 cycles mid-stream
    fork
      begin send(2, 0, 0); send(7, 1, 1); send(9, 1, 0); send(4, 0, 0); end
      begin repeat (2) @(posedge clk); #1 out_ready = 0; repeat (3) @(posedge clk); #1 out_ready = 1; end
    join
    drain();

    // Random items under random backpressure
    fork
      begin
        for (int i = 0; i < 30; i++)
          send($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      end
      begin
        repeat (60) begin @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1)); end
        out_ready = 1;
      end
    join
    out_ready = 1;
    drain();

    // Reset with two items in flight
    send(4, 0, 0); send(6, 0, 0);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    q.delete(); m_acc = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); chk("post_rst_idle", out_valid, 0); end
    @(posedge clk); #1;
    send(2, 0, 0);                      // -> 11
    drain();

    // Overridden instance: SCALE=5, OFFSET=4, WIDTH=8, OUT_WIDTH=10
    o_in_valid = 1; o_in_data = 200;
    @(negedge clk); chk("o_in_ready", o_in_ready, 1);
    @(posedge clk); #1 o_in_data = 255;
    @(posedge clk); #1 o_in_valid = 0;
    @(negedge clk); chk("o_valid_a", o_out_valid, 1); chk("o_data_a", o_out_data, 1004);
    @(negedge clk); chk("o_valid_b", o_out_valid, 1);
`ifdef SCALE_OFFSET_SAT_EN
    chk("o_data_b", o_out_data, 1023);
`else
    chk("o_data_b", o_out_data, 255);
`endif
    @(negedge clk); chk("o_drain", o_out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
